// File: rtl/subleq_sequencer.sv
// Purpose : SUBLEQ instruction sequencer. It fetches A,B,C at PC, computes mem[B]-mem[A],
//           writes the result back to B, and branches to C when the result is <= 0.
// Latency / backpressure : 6 cycles per instruction (LD_A..EXEC). There is no backpressure:
//           the RAM always accepts a write, and RUN only gates at instruction boundaries.
// Ports   : CLK/RST (async, active-high); RUN run level; dataRead/addrRead RAM read port
//           (1-cycle read); addrWrite/dataWrite/WE store port; PC, BUSY, HALTED status.
module subleq_sequencer #(
    parameter int unsigned    W         = 8,
    parameter logic [W-1:0]   RESET_PC  = '0,
    parameter logic [W-1:0]   HALT_ADDR = '1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         RUN,
    input  logic [W-1:0] dataRead,
    output logic [W-1:0] addrRead,
    output logic [W-1:0] addrWrite,
    output logic [W-1:0] dataWrite,
    output logic         WE,
    output logic [W-1:0] PC,
    output logic         BUSY,
    output logic         HALTED
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD_A = 3'd1,
        LD_B = 3'd2,
        LD_C = 3'd3,
        RD_A = 3'd4,
        RD_B = 3'd5,
        EXEC = 3'd6,
        HALT = 3'd7
    } state_t;

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] TWO   = W'(2);
    localparam logic [W-1:0] THREE = W'(3);

    state_t       state, state_nxt;
    logic [W-1:0] a_q, b_q, c_q, op_a_q;
    logic [W-1:0] res;
    logic         taken;

    // In EXEC the RAM returns mem[B] (addressed during RD_B); mem[A] was latched in op_a_q.
    assign res   = dataRead - op_a_q;
    // Sign bit covers 0x80 as negative; wrap-around is intentional.
    assign taken = res[W-1] | (res == '0);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; RUN matters only at instruction boundaries (IDLE, EXEC).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN ? LD_A : IDLE;
            LD_A:    state_nxt = LD_B;
            LD_B:    state_nxt = LD_C;
            LD_C:    state_nxt = RD_A;
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = EXEC;
            EXEC: begin
                if (taken && (c_q == HALT_ADDR)) begin
                    state_nxt = HALT;
                end else if (RUN) begin
                    state_nxt = LD_A;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; read address is presented one cycle before the data is consumed.
    always_comb begin
        addrRead  = PC;
        addrWrite = '0;
        dataWrite = '0;
        WE        = 1'b0;
        BUSY      = (state != IDLE) && (state != HALT);
        HALTED    = (state == HALT);
        case (state)
            LD_B:    addrRead = PC + ONE;
            LD_C:    addrRead = PC + TWO;
            RD_A:    addrRead = a_q;
            RD_B:    addrRead = b_q;
            EXEC: begin
                WE        = 1'b1;
                addrWrite = b_q;
                dataWrite = res;
            end
            default: addrRead = PC;
        endcase
    end

    // Operand and PC registers. Each operand is captured the cycle after its address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PC     <= RESET_PC;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            op_a_q <= '0;
        end else begin
            case (state)
                LD_B:    a_q    <= dataRead;
                LD_C:    b_q    <= dataRead;
                RD_A:    c_q    <= dataRead;
                RD_B:    op_a_q <= dataRead;
                EXEC:    PC     <= taken ? c_q : PC + THREE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_sequencer.sv
module tb_subleq_sequencer;

    logic       CLK;
    logic       RST;
    logic       RUN, run2;
    logic [7:0] rd1, ar1, aw1, dw1, pc1;
    logic [7:0] rd2, ar2, aw2, dw2, pc2;
    logic       we1, busy1, halted1;
    logic       we2, busy2, halted2;
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic       pk_we1, pk_we2;
    logic [7:0] pk_a, pk_d;
    int         checks = 0;
    int         errors = 0;

    subleq_sequencer #(.W(8), .RESET_PC(8'h00), .HALT_ADDR(8'hFF)) u_dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .dataRead(rd1), .addrRead(ar1),
        .addrWrite(aw1), .dataWrite(dw1), .WE(we1), .PC(pc1),
        .BUSY(busy1), .HALTED(halted1)
    );

    subleq_sequencer #(.W(8), .RESET_PC(8'hFE), .HALT_ADDR(8'hFF)) u_wrap (
        .CLK(CLK), .RST(RST), .RUN(run2), .dataRead(rd2), .addrRead(ar2),
        .addrWrite(aw2), .dataWrite(dw2), .WE(we2), .PC(pc2),
        .BUSY(busy2), .HALTED(halted2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM models: registered read, write on the edge where WE=1; bench pokes share the port.
    always @(posedge CLK) begin
        if (we1) mem1[aw1] <= dw1;
        else if (pk_we1) mem1[pk_a] <= pk_d;
        rd1 <= mem1[ar1];
    end

    always @(posedge CLK) begin
        if (we2) mem2[aw2] <= dw2;
        else if (pk_we2) mem2[pk_a] <= pk_d;
        rd2 <= mem2[ar2];
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic poke(input bit sel, input logic [7:0] a, input logic [7:0] d);
        pk_a   = a;
        pk_d   = d;
        pk_we1 = !sel;
        pk_we2 = sel;
        step(1);
        pk_we1 = 1'b0;
        pk_we2 = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(1);
        RST = 1'b0;
    endtask

    // Runs one instruction from IDLE with RUN held high until EXEC, then lets it drop to IDLE.
    task automatic run_one(input string tag, input logic [7:0] exp_aw,
                           input logic [7:0] exp_dw, input logic [7:0] exp_pc);
        RUN = 1'b1;
        step(6);
        checkb({tag, "_we"}, we1, 1'b1);
        check({tag, "_aw"}, aw1, exp_aw);
        check({tag, "_dw"}, dw1, exp_dw);
        RUN = 1'b0;
        step(1);
        check({tag, "_pc"}, pc1, exp_pc);
        checkb({tag, "_busy"}, busy1, 1'b0);
    endtask

    initial begin
        RST    = 1'b1;
        RUN    = 1'b0;
        run2   = 1'b0;
        pk_we1 = 1'b0;
        pk_we2 = 1'b0;
        pk_a   = 8'h00;
        pk_d   = 8'h00;

        // Program loading while held in reset
        poke(1'b0, 8'd0, 8'd10);
        poke(1'b0, 8'd1, 8'd11);
        poke(1'b0, 8'd2, 8'd20);
        poke(1'b0, 8'd10, 8'd3);
        poke(1'b0, 8'd11, 8'd5);
        poke(1'b1, 8'hFE, 8'h10);
        poke(1'b1, 8'hFF, 8'h11);
        poke(1'b1, 8'h00, 8'h40);
        poke(1'b1, 8'h10, 8'd2);
        poke(1'b1, 8'h11, 8'd5);

        checkb("rst_we", we1, 1'b0);
        checkb("rst_busy", busy1, 1'b0);
        checkb("rst_halted", halted1, 1'b0);
        check("rst_pc", pc1, 8'h00);
        check("rst_pc_wrap", pc2, 8'hFE);

        // Reset mid-instruction (in RD_A)
        RST = 1'b0;
        RUN = 1'b1;
        step(4);
        check("rda_addr", ar1, 8'd10);
        checkb("rda_busy", busy1, 1'b1);
        RST = 1'b1;
        RUN = 1'b0;
        #1;
        checkb("midrst_we", we1, 1'b0);
        check("midrst_pc", pc1, 8'h00);
        checkb("midrst_busy", busy1, 1'b0);
        checkb("midrst_halted", halted1, 1'b0);
        check("midrst_addr", ar1, 8'h00);
        step(1);
        RST = 1'b0;
        step(3);
        checkb("idle_busy", busy1, 1'b0);
        check("idle_nowrite", mem1[11], 8'd5);

        // No-branch instruction with per-cycle read address sequence
        RUN = 1'b1;
        step(1);
        check("seq_lda", ar1, 8'd0);
        step(1);
        check("seq_ldb", ar1, 8'd1);
        step(1);
        check("seq_ldc", ar1, 8'd2);
        step(1);
        check("seq_rda", ar1, 8'd10);
        step(1);
        check("seq_rdb", ar1, 8'd11);
        step(1);
        checkb("nb_we", we1, 1'b1);
        check("nb_aw", aw1, 8'd11);
        check("nb_dw", dw1, 8'd2);
        check("nb_pc_hold", pc1, 8'd0);
        RUN = 1'b0;
        step(1);
        check("nb_pc", pc1, 8'd3);
        checkb("nb_busy", busy1, 1'b0);
        checkb("nb_we_off", we1, 1'b0);
        check("nb_mem", mem1[11], 8'd2);

        // Branch cases
        do_reset();
        check("rst2_pc", pc1, 8'd0);
        poke(1'b0, 8'd10, 8'd5);
        poke(1'b0, 8'd11, 8'd5);
        run_one("zero", 8'd11, 8'h00, 8'd20);
        do_reset();
        poke(1'b0, 8'd10, 8'd1);
        poke(1'b0, 8'd11, 8'd0);
        run_one("neg", 8'd11, 8'hFF, 8'd20);
        do_reset();
        poke(1'b0, 8'd10, 8'h80);
        poke(1'b0, 8'd11, 8'h00);
        run_one("r80", 8'd11, 8'h80, 8'd20);
        do_reset();
        poke(1'b0, 8'd10, 8'h01);
        poke(1'b0, 8'd11, 8'h80);
        run_one("r7f", 8'd11, 8'h7F, 8'd3);
        do_reset();
        poke(1'b0, 8'd1, 8'd10);
        poke(1'b0, 8'd10, 8'd9);
        run_one("aeqb", 8'd10, 8'h00, 8'd20);
        check("aeqb_mem", mem1[10], 8'h00);

        // Halt
        do_reset();
        poke(1'b0, 8'd1, 8'd11);
        poke(1'b0, 8'd2, 8'hFF);
        poke(1'b0, 8'd10, 8'd7);
        poke(1'b0, 8'd11, 8'd7);
        RUN = 1'b1;
        step(6);
        checkb("halt_we", we1, 1'b1);
        check("halt_aw", aw1, 8'd11);
        check("halt_dw", dw1, 8'h00);
        step(1);
        checkb("halt_halted", halted1, 1'b1);
        checkb("halt_busy", busy1, 1'b0);
        checkb("halt_we_off", we1, 1'b0);
        check("halt_pc", pc1, 8'hFF);
        for (int i = 0; i < 20; i++) begin
            RUN = ~RUN;
            step(1);
            checkb("halt_hold_we", we1, 1'b0);
            check("halt_hold_pc", pc1, 8'hFF);
            checkb("halt_hold_halted", halted1, 1'b1);
        end
        RUN = 1'b0;
        do_reset();
        checkb("unhalt", halted1, 1'b0);

        // Address wrap on the RESET_PC=0xFE instance
        run2 = 1'b1;
        step(1);
        check("wrap_lda", ar2, 8'hFE);
        step(1);
        check("wrap_ldb", ar2, 8'hFF);
        step(1);
        check("wrap_ldc", ar2, 8'h00);
        step(3);
        checkb("wrap_we", we2, 1'b1);
        checkb("wrap_busy", busy2, 1'b1);
        check("wrap_aw", aw2, 8'h11);
        check("wrap_dw", dw2, 8'h03);
        run2 = 1'b0;
        step(1);
        check("wrap_pc", pc2, 8'h01);
        checkb("wrap_halted", halted2, 1'b0);

        // RUN dropped mid-instruction, then resumed
        poke(1'b0, 8'd2, 8'd20);
        poke(1'b0, 8'd10, 8'd3);
        poke(1'b0, 8'd11, 8'd5);
        poke(1'b0, 8'd3, 8'd12);
        poke(1'b0, 8'd4, 8'd13);
        poke(1'b0, 8'd5, 8'd30);
        poke(1'b0, 8'd12, 8'd1);
        poke(1'b0, 8'd13, 8'd9);
        RUN = 1'b1;
        step(3);
        RUN = 1'b0;
        step(3);
        checkb("drop_we", we1, 1'b1);
        check("drop_aw", aw1, 8'd11);
        check("drop_dw", dw1, 8'd2);
        step(1);
        checkb("drop_busy", busy1, 1'b0);
        check("drop_pc", pc1, 8'd3);
        for (int i = 0; i < 5; i++) begin
            checkb("drop_idle_we", we1, 1'b0);
            step(1);
        end
        RUN = 1'b1;
        step(1);
        check("resume_lda", ar1, 8'd3);
        step(5);
        checkb("resume_we", we1, 1'b1);
        check("resume_aw", aw1, 8'd13);
        check("resume_dw", dw1, 8'd8);
        RUN = 1'b0;
        step(1);
        check("resume_pc", pc1, 8'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
